// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the run/stop/clear counter controller.
// State encodings are fixed because o_state exposes them directly.
package counter_ctrl_pkg;

  localparam int MAX_COUNT_D = 9999;
  localparam int CNT_W_D     = 14;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Button, tick and status bundle between the panel and counter_ctrl.
// master drives buttons and tick; slave is the controller.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
);

  logic             i_btn_run;
  logic             i_btn_clear;
  logic             i_btn_mode;
  logic             i_tick;
  logic             o_tick_en;
  logic             o_tick_clr;
  logic [CNT_W-1:0] o_count;
  logic             o_mode;
  logic [1:0]       o_state;

  modport master (
    output i_btn_run, i_btn_clear, i_btn_mode, i_tick,
    input  o_tick_en, o_tick_clr, o_count, o_mode, o_state
  );

  modport slave (
    input  i_btn_run, i_btn_clear, i_btn_mode, i_tick,
    output o_tick_en, o_tick_clr, o_count, o_mode, o_state
  );

endinterface

// File: rtl/counter_ctrl_btn_edge.sv
// Two-flop synchronizer plus one delay flop per button.
// pulse is high for one cycle after each synchronized rising edge.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, s3;

  // synchronize the raw level, then keep one cycle of history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/counter_ctrl.sv
// Run/stop/clear controller with wrapping up/down count.
// Drives enable and clear of an external tick generator.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_D,
  parameter int CNT_W     = CNT_W_D
) (
  input logic           clk,
  input logic           rst,
  counter_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(MAX_COUNT);

  state_t           state;
  logic             tick_en;
  logic             tick_clr;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             run_ev, clr_ev, mode_ev;
  logic             step;

  btn_edge u_run (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.i_btn_run),
    .pulse (run_ev)
  );

  btn_edge u_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.i_btn_clear),
    .pulse (clr_ev)
  );

  btn_edge u_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.i_btn_mode),
    .pulse (mode_ev)
  );

  // FSM with Moore outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_STOP;
      tick_en  <= 1'b0;
      tick_clr <= 1'b0;
    end else begin
      state    <= ST_STOP;
      tick_en  <= 1'b0;
      tick_clr <= 1'b0;
      case (state)
        ST_STOP: begin
          if (run_ev) begin
            state   <= ST_RUN;
            tick_en <= 1'b1;
          end else if (clr_ev) begin
            state    <= ST_CLEAR;
            tick_clr <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!run_ev) begin
            state   <= ST_RUN;
            tick_en <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign step = (state == ST_RUN) && bus.i_tick;

  // count steps on the pre-toggle mode; mode toggles in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      mode  <= 1'b0;
    end else begin
      if (mode_ev) mode <= ~mode;
      unique case (1'b1)
        (state == ST_CLEAR): count <= '0;
        (step && !mode):
          count <= (count == MAXV) ? '0 : count + 1'b1;
        (step && mode):
          count <= (count == '0) ? MAXV : count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.o_tick_en  = tick_en;
  assign bus.o_tick_clr = tick_clr;
  assign bus.o_count    = count;
  assign bus.o_mode     = mode;
  assign bus.o_state    = state;

endmodule
